// File: rtl/interrupt_request_unit.sv
// IRR stage of an 8259-style PIC: synchronises and glitch-filters the IR pins,
// detects edges and keeps the per-channel request, deferred and overrun state.
module interrupt_request_unit #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               write_initial_command_word_1,
    input  logic [NUM_IRQ-1:0] trigger_mode,
    input  logic               freeze,
    input  logic [NUM_IRQ-1:0] clear_interrupt_request,
    input  logic [NUM_IRQ-1:0] clear_overrun,
    input  logic [NUM_IRQ-1:0] interrupt_request_pin,
    output logic [NUM_IRQ-1:0] interrupt_request_register,
    output logic [NUM_IRQ-1:0] overrun_flag,
    output logic               any_request
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync;
    logic [NUM_IRQ-1:0] filtered;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] irr_q;
    logic [NUM_IRQ-1:0] irr_d;
    logic [NUM_IRQ-1:0] deferred_q;
    logic [NUM_IRQ-1:0] deferred_d;
    logic [NUM_IRQ-1:0] overrun_q;
    logic [NUM_IRQ-1:0] overrun_d;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] overrun_set;

    // Plain flop chain; the first stage is the only one that sees the raw pin.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= interrupt_request_pin;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_LEN > 0) begin : g_filter
            localparam int CNT_W = $clog2(FILTER_LEN + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

            for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
                logic [CNT_W-1:0] cnt_q;
                logic             level_q;

                // A new level is accepted only after FILTER_LEN consecutive mismatches.
                always_ff @(posedge clock) begin
                    if (reset) begin
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else if (sync[i] == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        level_q <= sync[i];
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                assign filtered[i] = level_q;
            end
        end else begin : g_bypass
            assign filtered = sync;
        end
    endgenerate

    assign rise = filtered & ~prev_q;

    always_comb begin
        irr_d       = irr_q;
        deferred_d  = deferred_q;
        edge_set    = rise | deferred_q;
        if (!freeze) begin
            // A set in the same cycle as a clear wins, so no edge is ever dropped.
            irr_d = (trigger_mode & filtered & ~clear_interrupt_request)
                  | (~trigger_mode & ((irr_q & ~clear_interrupt_request) | edge_set));
            deferred_d = '0;
        end else begin
            irr_d      = irr_q & ~clear_interrupt_request;
            deferred_d = deferred_q | (rise & ~trigger_mode);
        end
        overrun_set = ~trigger_mode & rise
                    & ((irr_q & ~clear_interrupt_request) | deferred_q);
        overrun_d   = (overrun_q & ~clear_overrun) | overrun_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q     <= '0;
            irr_q      <= '0;
            deferred_q <= '0;
            overrun_q  <= '0;
        end else if (write_initial_command_word_1) begin
            // prev all ones forces a fresh low-to-high before the next edge request.
            prev_q     <= '1;
            irr_q      <= '0;
            deferred_q <= '0;
            overrun_q  <= '0;
        end else begin
            prev_q     <= filtered;
            irr_q      <= irr_d;
            deferred_q <= deferred_d;
            overrun_q  <= overrun_d;
        end
    end

    assign interrupt_request_register = irr_q;
    assign overrun_flag               = overrun_q;
    assign any_request                = |irr_q;

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Directed bench for interrupt_request_unit: the driver queues hand-computed
// expectations tagged with a cycle number, the monitor checks them at negedge.
module tb_interrupt_request_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       icw1;
    logic [7:0] trigger_mode;
    logic       freeze;
    logic [7:0] clr;
    logic [7:0] clov;
    logic [7:0] pin;
    logic [7:0] irr;
    logic [7:0] ovr;
    logic       any;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] irr;
        logic [7:0] ovr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   flush = 1'b0;

    interrupt_request_unit dut (
        .clock                        (clock),
        .reset                        (reset),
        .write_initial_command_word_1 (icw1),
        .trigger_mode                 (trigger_mode),
        .freeze                       (freeze),
        .clear_interrupt_request      (clr),
        .clear_overrun                (clov),
        .interrupt_request_pin        (pin),
        .interrupt_request_register   (irr),
        .overrun_flag                 (ovr),
        .any_request                  (any)
    );

    // clock / cycle count
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // monitor / scoreboard
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (mon_e.cyc != cyc || irr !== mon_e.irr || ovr !== mon_e.ovr
                || any !== (|mon_e.irr)) begin
                miscompares++;
                $display("FAIL %s cyc=%0d/%0d got irr=%h ovr=%h any=%b, expected irr=%h ovr=%h any=%b",
                         mon_e.name, cyc, mon_e.cyc, irr, ovr, any,
                         mon_e.irr, mon_e.ovr, |mon_e.irr);
            end
        end
        if (flush) begin
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                miscompares++;
                $display("FAIL %s never checked (due cyc %0d, now %0d)", mon_e.name, mon_e.cyc, cyc);
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_at(input int d, input string nm, input logic [7:0] e_irr,
                             input logic [7:0] e_ovr);
        exp_t e;
        e.cyc  = cyc + d;
        e.name = nm;
        e.irr  = e_irr;
        e.ovr  = e_ovr;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; icw1 = 1'b0; trigger_mode = 8'h00; freeze = 1'b0;
        clr = 8'h00; clov = 8'h00; pin = 8'h00;
        tick(2);
        expect_at(0, "reset", 8'h00, 8'h00);
        reset = 1'b0;
        tick(1);

        // edge mode: latency, clear, no re-trigger while held high
        pin = 8'h01;
        expect_at(4, "t1_latency", 8'h00, 8'h00);
        expect_at(5, "t1_set", 8'h01, 8'h00);
        tick(5);
        clr = 8'h01;
        expect_at(1, "t1_clear", 8'h00, 8'h00);
        tick(1); clr = 8'h00;
        expect_at(3, "t1_no_retrig", 8'h00, 8'h00);
        tick(3);
        pin = 8'h00;
        tick(6);

        // level mode on channel 3
        trigger_mode = 8'h08; pin = 8'h08;
        expect_at(4, "t2_latency", 8'h00, 8'h00);
        expect_at(5, "t2_level_set", 8'h08, 8'h00);
        tick(5);
        clr = 8'h08;
        expect_at(1, "t2_clear_drop", 8'h00, 8'h00);
        expect_at(2, "t2_clear_return", 8'h08, 8'h00);
        tick(1); clr = 8'h00;
        tick(1);
        pin = 8'h00;
        expect_at(4, "t2_hold", 8'h08, 8'h00);
        expect_at(5, "t2_level_drop", 8'h00, 8'h00);
        tick(5);
        trigger_mode = 8'h00;
        tick(1);

        // glitch filter
        pin = 8'hFF;
        tick(1); pin = 8'h00;
        expect_at(5, "t3_glitch", 8'h00, 8'h00);
        tick(6);
        pin = 8'h80;
        expect_at(5, "t3_pulse2", 8'h80, 8'h00);
        tick(2); pin = 8'h00;
        tick(3);
        expect_at(3, "t3_pulse_hold", 8'h80, 8'h00);
        tick(3);
        clr = 8'h80;
        expect_at(1, "t3_clear", 8'h00, 8'h00);
        tick(1); clr = 8'h00;
        tick(4);

        // freeze with deferred capture
        pin = 8'h01;
        expect_at(5, "t4_bit0", 8'h01, 8'h00);
        tick(5);
        freeze = 1'b1; pin = 8'h05;
        expect_at(5, "t4_frozen", 8'h01, 8'h00);
        tick(5);
        clr = 8'h01;
        expect_at(1, "t4_frozen_clear", 8'h00, 8'h00);
        tick(1); clr = 8'h00; freeze = 1'b0;
        expect_at(1, "t4_unfreeze", 8'h04, 8'h00);
        tick(1);
        clr = 8'h04;
        expect_at(1, "t4_cleared", 8'h00, 8'h00);
        tick(1); clr = 8'h00; pin = 8'h00;
        tick(6);

        // overrun on channel 5
        pin = 8'h20;
        expect_at(5, "t5_first", 8'h20, 8'h00);
        tick(5);
        pin = 8'h00;
        tick(5);
        pin = 8'h20;
        expect_at(4, "t5_pre_ovr", 8'h20, 8'h00);
        expect_at(5, "t5_overrun", 8'h20, 8'h20);
        tick(5);
        clov = 8'h20;
        expect_at(1, "t5_ovr_clear", 8'h20, 8'h00);
        tick(1); clov = 8'h00;
        clr = 8'h20;
        expect_at(1, "t5_irr_clear", 8'h00, 8'h00);
        tick(1); clr = 8'h00; pin = 8'h00;
        tick(6);

        // ICW1 soft clear, then reset in the middle of a freeze
        pin = 8'hFF;
        expect_at(5, "t6_all_set", 8'hFF, 8'h00);
        tick(5);
        icw1 = 1'b1;
        expect_at(1, "t6_icw1", 8'h00, 8'h00);
        tick(1); icw1 = 1'b0;
        expect_at(4, "t6_no_retrig", 8'h00, 8'h00);
        tick(4);
        pin = 8'h00;
        tick(5);
        pin = 8'hFF;
        expect_at(5, "t6_fresh_edge", 8'hFF, 8'h00);
        tick(5);
        freeze = 1'b1; pin = 8'h00;
        tick(5);
        pin = 8'hFF;
        expect_at(5, "t6_frozen_ovr", 8'hFF, 8'hFF);
        tick(5);
        reset = 1'b1;
        expect_at(1, "t6_reset", 8'h00, 8'h00);
        tick(1); reset = 1'b0; freeze = 1'b0;
        expect_at(1, "t6_post_reset", 8'h00, 8'h00);
        tick(1);

        // drain with a bounded wait, then report anything left unchecked
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1);
        flush = 1'b1;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interrupt_request_unit.md
Name: interrupt_request_unit

Overview:
- Parametrised next-generation Interrupt Request Register (IRR) stage for the 8259-style PIC.
- Synchronises and glitch-filters NUM_IRQ request pins, then detects edges.
- Supports a level or edge trigger mode per channel, freeze with deferred capture, and per-channel overrun flags.
- Feeds interrupt_request_register to the priority resolver / in-service logic.

Parameters:
- NUM_IRQ, 8: number of request channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per pin (>=1).
- FILTER_LEN, 2: consecutive cycles a new level must persist before it is accepted; 0 = filter bypassed.

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- write_initial_command_word_1  in  1  ICW1 write strobe; synchronous soft clear (see below)
- trigger_mode  in  NUM_IRQ  per channel: 1 = level triggered, 0 = edge triggered
- freeze  in  1  hold IRR against new sets (asserted during INTA sequence)
- clear_interrupt_request  in  NUM_IRQ  per-channel clear of the IRR bit
- clear_overrun  in  NUM_IRQ  per-channel clear of overrun_flag
- interrupt_request_pin  in  NUM_IRQ  asynchronous IR pins
- interrupt_request_register  out  NUM_IRQ  IRR contents
- overrun_flag  out  NUM_IRQ  sticky flag: an edge arrived while a request was already pending
- any_request  out  1  OR-reduction of interrupt_request_register (registered-path combinational)

Behaviour:
- Reset
  - reset=1 at a clock edge sets every register to 0: sync chain, filter counters, filtered level, prev level, IRR, deferred, overrun.
  - Outputs read 0 on the cycle after reset. reset has priority over all other inputs.
- Synchroniser
  - sync[i] is interrupt_request_pin[i] delayed by SYNC_STAGES flops.
- Filter, per channel
  - Counter width is clog2(FILTER_LEN+1).
  - If sync == filtered: counter <= 0.
  - Else if counter == FILTER_LEN-1: filtered <= sync and counter <= 0.
  - Else: counter++.
  - FILTER_LEN=0: filtered = sync, no counter.
  - A pulse shorter than FILTER_LEN cycles never reaches filtered.
- Edge detect
  - prev <= filtered every cycle.
  - rise = filtered & ~prev.
- IRR next state, per channel, not frozen
  - Level mode: irr <= filtered & ~clear.
  - Edge mode: irr <= (irr | rise | deferred) & ~clear | (rise | deferred). A same-cycle set beats the clear, so a new request is never lost.
  - deferred <= 0.
- IRR next state, frozen
  - irr <= irr & ~clear. Clears still act; sets are blocked.
  - Edge mode: deferred <= deferred | rise. Deferred edges merge into the IRR on the first unfrozen cycle.
  - Level mode: no deferral; the IRR re-samples filtered after unfreeze.
- Overrun (edge mode only)
  - overrun sets when rise=1 and either (irr=1 and clear=0) or deferred=1.
  - It holds until clear_overrun. A same-cycle set wins over clear_overrun.
- write_initial_command_word_1 (when reset=0)
  - Clears IRR, deferred and overrun.
  - Sets prev to all ones, so a pin already high needs a fresh low-to-high transition before an edge-mode request is taken.
  - Sync chain and filter continue unaffected. Takes priority over freeze, set and clear on that cycle.
- Trigger mode change
  - Takes effect on the next edge; the IRR bit is not cleared by the change.
  - Level mode recomputes from filtered at once.
- Latency
  - From a pin change (sampled at edge k) to interrupt_request_register: SYNC_STAGES + FILTER_LEN + 1 cycles.
  - Defaults give 5 cycles. With FILTER_LEN=0, SYNC_STAGES+1.
- Reset mid-operation: synchronous full clear; no pending, deferred or overrun state survives.

Test Plan:
- Defaults, all channels edge mode; pin 8'h01 rises at edge 0 -> IRR=8'h01 from edge 5; clear_interrupt_request=8'h01 for 1 cycle -> IRR=8'h00; pin held high -> stays 8'h00 (no re-trigger).
- Level mode on channel 3; pin 8'h08 high -> IRR=8'h08 after 5 cycles; clear pulse -> bit drops 1 cycle then returns to 1; pin low -> IRR=8'h00 after 5 cycles.
- Glitch filter: 1-cycle pin pulses on all channels -> IRR stays 8'h00; 2-cycle pulse on channel 7, edge mode -> IRR=8'h80.
- Freeze: freeze=1, edge on channel 2 -> IRR unchanged, clear of existing bit 0 still works; freeze=0 -> IRR bit 2 set the next cycle, overrun=0.
- Overrun: channel 5 edge, pin low, then second edge before clear -> overrun_flag=8'h20; clear_overrun=8'h20 -> 8'h00.
- write_initial_command_word_1 with pins 8'hFF high and IRR=8'hFF -> IRR=8'h00 and no new edge-mode requests until the pins go low then high; reset mid-freeze with deferred set -> all outputs 0 the next cycle.
